// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 Sobel/Prewitt gradient engine.
// Accepts one unsigned pixel per valid/ready handshake in raster order and emits
// registered signed Gx/Gy, an L1 magnitude and an end-of-line flag for every
// fully-populated interior window.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   valid_i/ready_o      input pixel handshake; data_i pixel, sof_i frame start
//   cols_i, mode_i       image width and kernel select, sampled on an sof pixel
//   valid_o/ready_i      output handshake
//   gx_o, gy_o, mag_o    gradients and |gx|+|gy|; eol_o last window of the row
module conv2d_stream #(
  parameter int unsigned WIDTH_P    = 8,
  parameter int unsigned MAX_COLS_P = 640
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [WIDTH_P-1:0]                    data_i,
  input  logic                                  sof_i,
  input  logic [$clog2(MAX_COLS_P+1)-1:0]       cols_i,
  input  logic                                  mode_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic signed [WIDTH_P+2:0]             gx_o,
  output logic signed [WIDTH_P+2:0]             gy_o,
  output logic [WIDTH_P+2:0]                    mag_o,
  output logic                                  eol_o
);

  localparam int unsigned CW = $clog2(MAX_COLS_P + 1);
  localparam int unsigned AW = $clog2(MAX_COLS_P);
  localparam int unsigned GW = WIDTH_P + 3;

  // Position / frame configuration state
  logic [1:0]    row_q;
  logic [CW-1:0] col_q;
  logic [CW-1:0] cols_q;
  logic          mode_q;

  // Window columns 0 and 1, indexed [row] with 0 = top
  logic [2:0][WIDTH_P-1:0] c0_q, c1_q;

  // Line buffers: lb1 two rows ago, lb0 one row ago
  logic [WIDTH_P-1:0] lb1 [MAX_COLS_P];
  logic [WIDTH_P-1:0] lb0 [MAX_COLS_P];

  logic                    accept;
  logic [1:0]              eff_row;
  logic [CW-1:0]           eff_col, eff_cols, cols_clamp;
  logic                    eff_mode, last_col, emit;
  logic [AW-1:0]           idx;
  logic [2:0][WIDTH_P-1:0] c2;
  logic signed [GW-1:0]    dx0, dx1, dx2, dy0, dy1, dy2, gx, gy;
  logic [GW-1:0]           ax, ay, mag;

  function automatic logic signed [GW-1:0] ext(input logic [WIDTH_P-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign accept  = valid_i & ready_o;
  assign ready_o = rstn_i & (~valid_o | ready_i);

  // Effective position/config for the pixel on the inputs (sof forces 0,0 and reloads config)
  always_comb begin
    cols_clamp = cols_i;
    if (cols_i < CW'(3))                 cols_clamp = CW'(3);
    else if (cols_i > CW'(MAX_COLS_P))   cols_clamp = CW'(MAX_COLS_P);
    eff_row  = sof_i ? 2'd0 : row_q;
    eff_col  = sof_i ? '0 : col_q;
    eff_cols = sof_i ? cols_clamp : cols_q;
    eff_mode = sof_i ? mode_i : mode_q;
    last_col = (eff_col == eff_cols - CW'(1));
    emit     = (eff_row == 2'd2) && (eff_col >= CW'(2));
    idx      = eff_col[AW-1:0];
    c2       = {data_i, lb0[idx], lb1[idx]};
  end

  // Kernel arithmetic on the window {c0_q, c1_q, c2}
  always_comb begin
    dx0 = ext(c2[0]) - ext(c0_q[0]);
    dx1 = ext(c2[1]) - ext(c0_q[1]);
    dx2 = ext(c2[2]) - ext(c0_q[2]);
    dy0 = ext(c0_q[2]) - ext(c0_q[0]);
    dy1 = ext(c1_q[2]) - ext(c1_q[0]);
    dy2 = ext(c2[2]) - ext(c2[0]);
    gx  = dx0 + (eff_mode ? dx1 : (dx1 <<< 1)) + dx2;
    gy  = dy0 + (eff_mode ? dy1 : (dy1 <<< 1)) + dy2;
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag = ax + ay;
  end

  // Position counters, frame config and window shift
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row_q  <= 2'd0;
      col_q  <= '0;
      cols_q <= CW'(MAX_COLS_P);
      mode_q <= 1'b0;
      c0_q   <= '0;
      c1_q   <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
      end else begin
        col_q <= eff_col + CW'(1);
        row_q <= eff_row;
      end
      cols_q <= eff_cols;
      mode_q <= eff_mode;
      c0_q   <= c1_q;
      c1_q   <= c2;
    end
  end

  // Line buffer update; contents are never cleared, emit gating hides stale data
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= data_i;
    end
  end

  // Output register: load on emit, hold under backpressure, clear when drained
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      gx_o    <= '0;
      gy_o    <= '0;
      mag_o   <= '0;
      eol_o   <= 1'b0;
    end else if (accept && emit) begin
      valid_o <= 1'b1;
      gx_o    <= gx;
      gy_o    <= gy;
      mag_o   <= mag;
      eol_o   <= last_col;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;
  localparam int unsigned W  = 8;
  localparam int unsigned MC = 640;
  localparam int unsigned CW = $clog2(MC + 1);
  localparam int unsigned GW = W + 3;

  logic clk_i = 1'b0;
  logic rstn_i, valid_i, ready_o, sof_i, mode_i, valid_o, ready_i, eol_o;
  logic [W-1:0] data_i;
  logic [CW-1:0] cols_i;
  logic signed [GW-1:0] gx_o, gy_o;
  logic [GW-1:0] mag_o;

  conv2d_stream #(.WIDTH_P(W), .MAX_COLS_P(MC)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .sof_i(sof_i), .cols_i(cols_i), .mode_i(mode_i),
    .valid_o(valid_o), .ready_i(ready_i), .gx_o(gx_o), .gy_o(gy_o),
    .mag_o(mag_o), .eol_o(eol_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { int gx; int gy; int mag; bit eol; } out_t;

  out_t cap[$];
  out_t exp_q[$];
  out_t ref_q[$];
  int img [8][8];
  int checks = 0;
  int errors = 0;
  int cycles = 0;

  // One clock cycle: inputs already set at the negedge; sample handshakes, advance.
  task automatic step(input bit rdy, output bit acc);
    out_t o;
    ready_i = rdy;
    #1;
    acc = valid_i && ready_o;
    if (valid_o && ready_i) begin
      o.gx = int'(gx_o); o.gy = int'(gy_o); o.mag = int'(mag_o); o.eol = eol_o;
      cap.push_back(o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cycles++;
  endtask

  task automatic send_pixel(input int pix, input bit sof, input int cols, input bit mode, input int stall);
    bit acc;
    int n;
    n = 0;
    valid_i = 1'b1; data_i = W'(pix); sof_i = sof; cols_i = CW'(cols); mode_i = mode;
    do begin
      step(int'($urandom_range(99)) >= stall, acc);
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout got no accept within %0d cycles required accept", n);
    end
    valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int cols_field, input int cols, input bit mode, input int stall);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        send_pixel(img[r][c], (r == 0 && c == 0), cols_field, mode, stall);
  endtask

  task automatic drain();
    bit acc;
    valid_i = 1'b0;
    repeat (4) step(1'b1, acc);
  endtask

  // Reference: direct 3x3 kernel evaluation over every interior window of img
  task automatic model_frame(input int rows, input int cols, input bit mode);
    int w [3];
    out_t o;
    int gx, gy;
    w[0] = 1; w[1] = mode ? 1 : 2; w[2] = 1;
    for (int r0 = 0; r0 + 2 < rows; r0++)
      for (int c0 = 0; c0 + 2 < cols; c0++) begin
        gx = 0; gy = 0;
        for (int k = 0; k < 3; k++) begin
          gx += w[k] * (img[r0 + k][c0 + 2] - img[r0 + k][c0]);
          gy += w[k] * (img[r0 + 2][c0 + k] - img[r0][c0 + k]);
        end
        o.gx = gx; o.gy = gy;
        o.mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        o.eol = (c0 + 2 == cols - 1);
        exp_q.push_back(o);
      end
  endtask

  task automatic fill_random(input int rows, input int cols, input bit binary);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        img[r][c] = binary ? (($urandom_range(1) == 1) ? 255 : 0) : int'($urandom_range(255));
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; valid_i = 1'b0; sof_i = 1'b0; mode_i = 1'b0; ready_i = 1'b1;
    data_i = '0; cols_i = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got ready_o=%b valid_o=%b required 0 0", ready_o, valid_o);
    end
    rstn_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || gx_o !== '0 || gy_o !== '0 || mag_o !== '0 || eol_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got ready=%b valid=%b gx=%0d gy=%0d mag=%0d eol=%b required 1 0 0 0 0 0",
               ready_o, valid_o, gx_o, gy_o, mag_o, eol_o);
    end
  endtask

  task automatic test_constant();
    cap.delete(); exp_q.delete();
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 100;
    model_frame(5, 5, 1'b0);
    send_frame(5, 5, 5, 1'b0, 0);
    drain();
    checks++;
    if (cap.size() !== exp_q.size()) begin
      errors++; $display("FAIL const_count got %0d required %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL const_out[%0d] got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                 i, cap[i].gx, cap[i].gy, cap[i].mag, cap[i].eol, exp_q[i].gx, exp_q[i].gy, exp_q[i].mag, exp_q[i].eol);
      end
    end
  endtask

  task automatic test_vertical();
    for (int m = 0; m < 2; m++) begin
      cap.delete(); exp_q.delete();
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r][c] = (c >= 2) ? 255 : 0;
      model_frame(4, 4, m[0]);
      send_frame(4, 4, 4, m[0], 0);
      drain();
      checks++;
      if (cap.size() !== 4) begin
        errors++; $display("FAIL vert_count mode=%0d got %0d required 4", m, cap.size());
      end
      for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
        checks++;
        if (cap[i] !== exp_q[i] || cap[i].gx !== (m == 1 ? 765 : 1020) || cap[i].gy !== 0) begin
          errors++;
          $display("FAIL vert_out mode=%0d [%0d] got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                   m, i, cap[i].gx, cap[i].gy, cap[i].mag, cap[i].eol, exp_q[i].gx, exp_q[i].gy, exp_q[i].mag, exp_q[i].eol);
        end
      end
    end
  endtask

  task automatic test_horizontal();
    cap.delete(); exp_q.delete();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = (r == 2) ? 255 : 0;
    model_frame(3, 3, 1'b0);
    send_frame(3, 3, 3, 1'b0, 0);
    drain();
    checks++;
    if (cap.size() !== 1) begin
      errors++; $display("FAIL horiz_count got %0d required 1", cap.size());
    end else begin
      checks++;
      if (cap[0] !== exp_q[0] || cap[0].gy !== 1020 || cap[0].mag !== 1020 || cap[0].gx !== 0) begin
        errors++;
        $display("FAIL horiz_out got gx=%0d gy=%0d mag=%0d required gx=0 gy=1020 mag=1020",
                 cap[0].gx, cap[0].gy, cap[0].mag);
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    cap.delete(); exp_q.delete();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) img[r][c] = 10 * r + c;
    model_frame(6, 6, 1'b0);
    c0 = cycles;
    send_frame(6, 6, 6, 1'b0, 0);
    checks++;
    if (cycles - c0 !== 36) begin
      errors++; $display("FAIL throughput got %0d cycles required 36", cycles - c0);
    end
    drain();
    ref_q = cap;
    cap.delete();
    send_frame(6, 6, 6, 1'b0, 50);
    drain();
    checks++;
    if (cap.size() !== 16 || ref_q.size() !== 16) begin
      errors++; $display("FAIL bp_count got %0d and %0d required 16", cap.size(), ref_q.size());
    end
    for (int i = 0; i < cap.size() && i < ref_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap[i] !== ref_q[i] || cap[i] !== exp_q[i] || cap[i].gx !== 8 || cap[i].gy !== 80) begin
        errors++;
        $display("FAIL bp_out[%0d] got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                 i, cap[i].gx, cap[i].gy, cap[i].mag, cap[i].eol, exp_q[i].gx, exp_q[i].gy, exp_q[i].mag, exp_q[i].eol);
      end
    end
  endtask

  task automatic test_resync();
    cap.delete(); exp_q.delete();
    fill_random(6, 6, 1'b0);
    for (int p = 0; p < 9; p++) send_pixel(img[p / 6][p % 6], (p == 0), 6, 1'b0, 30);
    fill_random(4, 5, 1'b0);
    model_frame(4, 5, 1'b1);
    send_frame(4, 5, 5, 1'b1, 30);
    drain();
    checks++;
    if (cap.size() !== exp_q.size()) begin
      errors++; $display("FAIL resync_count got %0d required %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL resync_out[%0d] got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                 i, cap[i].gx, cap[i].gy, cap[i].mag, cap[i].eol, exp_q[i].gx, exp_q[i].gy, exp_q[i].mag, exp_q[i].eol);
      end
    end
  endtask

  task automatic test_reset_mid();
    cap.delete(); exp_q.delete();
    fill_random(5, 5, 1'b0);
    for (int p = 0; p < 13; p++) send_pixel(img[p / 5][p % 5], (p == 0), 5, 1'b0, 100);
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++; $display("FAIL stall_hold got valid=%b ready=%b required 1 0", valid_o, ready_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || mag_o !== '0) begin
      errors++; $display("FAIL async_reset got valid=%b ready=%b mag=%0d required 0 0 0", valid_o, ready_o, mag_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    cap.delete();
    fill_random(3, 3, 1'b0);
    model_frame(3, 3, 1'b0);
    send_frame(3, 3, 3, 1'b0, 20);
    drain();
    checks++;
    if (cap.size() !== 1) begin
      errors++; $display("FAIL post_reset_count got %0d required 1", cap.size());
    end else begin
      checks++;
      if (cap[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL post_reset_out got gx=%0d gy=%0d mag=%0d required gx=%0d gy=%0d mag=%0d",
                 cap[0].gx, cap[0].gy, cap[0].mag, exp_q[0].gx, exp_q[0].gy, exp_q[0].mag);
      end
    end
  endtask

  task automatic test_clamp();
    cap.delete(); exp_q.delete();
    fill_random(3, 3, 1'b1);
    model_frame(3, 3, 1'b0);
    send_frame(3, 1, 3, 1'b0, 0);
    drain();
    checks++;
    if (cap.size() !== 1) begin
      errors++; $display("FAIL clamp_count got %0d required 1", cap.size());
    end else begin
      checks++;
      if (cap[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL clamp_out got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                 cap[0].gx, cap[0].gy, cap[0].mag, cap[0].eol, exp_q[0].gx, exp_q[0].gy, exp_q[0].mag, exp_q[0].eol);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rows, cols;
    bit mode;
    cap.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      rows = int'($urandom_range(8, 3));
      cols = int'($urandom_range(8, 3));
      mode = 1'($urandom_range(1));
      fill_random(rows, cols, k < 2);
      model_frame(rows, cols, mode);
      send_frame(rows, cols, cols, mode, 30);
    end
    drain();
    checks++;
    if (cap.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d required %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d] got gx=%0d gy=%0d mag=%0d eol=%0d required gx=%0d gy=%0d mag=%0d eol=%0d",
                 i, cap[i].gx, cap[i].gy, cap[i].mag, cap[i].eol, exp_q[i].gx, exp_q[i].gy, exp_q[i].mag, exp_q[i].eol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_vertical();
    test_horizontal();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
